encoder8to3_seq: RTL and testbench
==================================

# encoder8to3_seq

Sequential 8-to-3 encoder that accepts a multi-hot 8-bit request vector over a valid/ready handshake and emits the 3-bit binary index of each set bit as a separate token, one per accepted output handshake. It is the encode-side counterpart of the team's 3-to-8 one-hot decoder: feeding each emitted code into that decoder and OR-ing the results reproduces the captured vector. It sits between request/event sources and any consumer that addresses lines by binary index.

## Interface
- LSB_FIRST, default 1: service order. 1 means the lowest set index goes first. 0 means the highest set index goes first.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- req_in  input  8  request vector; bit i set requests code i.
- req_valid  input  1  req_in is valid this cycle.
- req_ready  output  1  block can capture a vector; equals (state == IDLE).
- code  output  3  binary index of the bit currently being offered; registered.
- code_valid  output  1  code is valid; registered.
- code_ready  input  1  consumer accepts code this cycle.
- code_last  output  1  offered code is the final one of the current vector; registered.
- multi  output  1  captured vector had more than one bit set; registered, held for the whole batch.
- err_zero  output  1  one-cycle pulse when an all-zero vector is accepted; registered.

## Operation
- Reset values: state = IDLE, pending = 8'h00, code = 3'd0, code_valid = 0, code_last = 0, multi = 0, err_zero = 0. req_ready is 1 in the first cycle after reset.
- Internal register pending[7:0] holds the bits not yet served.
- **IDLE state**
  - Capture occurs when req_valid && req_ready.
  - Capture with req_in != 0:
    - pending <= req_in.
    - code <= priority index of req_in.
    - code_valid <= 1.
    - code_last <= (popcount(req_in) == 1).
    - multi <= (popcount(req_in) > 1).
    - Move to SERVE.
  - Capture with req_in == 0:
    - Vector is consumed.
    - err_zero <= 1 for exactly one cycle.
    - Stay in IDLE; no code is emitted.
- **SERVE state**
  - req_ready = 0; req_valid is ignored.
  - On code_valid && code_ready, bit[code] is cleared from pending, giving rem = pending & ~(1 << code).
  - If rem != 0:
    - code <= priority index of rem.
    - code_last <= (popcount(rem) == 1).
    - code_valid stays 1.
  - If rem == 0:
    - code_valid <= 0, code_last <= 0, multi <= 0.
    - Move to IDLE.
  - Without code_ready, code, code_last and multi hold stable. code_valid never deasserts without a handshake.
- Priority index:
  - LSB_FIRST=1: the smallest i with bit i set.
  - LSB_FIRST=0: the largest such i.
  - Purely combinational ahead of the output registers.
- Codes are unsigned 3-bit values 0..7 with no wrap. A batch produces exactly popcount(vector) codes, each emitted once.
- rst in any state, including mid-batch, discards pending immediately and returns all outputs to reset values on the next edge. No partial batch resumes.

## Timing
- Capture at edge N puts the first code on code at N+1 with code_valid=1. Latency is 1 cycle.
- With code_ready held high, SERVE emits one code per cycle. A vector with k set bits occupies cycles N+1 .. N+k.
- The final handshake at edge M returns the block to IDLE. req_ready is 1 in cycle M+1, and the next capture can occur at edge M+1. The minimum period for back-to-back vectors is k+1 cycles.
- err_zero is high for exactly the cycle after the zero-vector capture. req_ready stays 1 throughout, so zero vectors can be accepted every cycle.
- code_ready asserted while code_valid=0 has no effect.

## Test plan
- Reset, then req_in=8'b0010_0000 with req_valid=1 and code_ready=1, LSB_FIRST=1. Required: code=5 with code_valid=1, code_last=1, multi=0 one cycle after capture; req_ready=1 two cycles after capture.
- req_in=8'b1000_0101 with code_ready=1, LSB_FIRST=1. Required: codes 0, 2, 7 on consecutive cycles; multi=1 throughout; code_last only on 7.
- Same vector with LSB_FIRST=0. Required: codes 7, 2, 0 on consecutive cycles.
- req_in=8'hFF, with code_ready toggled 1,0,0,1,... Required: codes 0..7 each seen exactly once; code and code_last stable while code_ready=0; 8 handshakes total.
- req_in=8'h00 with req_valid=1. Required: err_zero=1 for one cycle, code_valid stays 0, req_ready stays 1.
- req_in=8'h0F, assert rst after the second handshake. Required: next cycle code_valid=0, multi=0, code=0 and req_ready=1; a fresh req_in=8'h10 then yields code=4.

Source files
------------

// File: rtl/encoder8to3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot request vector and
// emits the binary index of each set bit as one token per handshake.
module encoder8to3_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_in,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       code_last,
    output logic       multi,
    output logic       err_zero
);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t     state, state_d;
    logic [7:0] pending, pending_d;
    logic [2:0] code_d;
    logic       valid_d;
    logic       last_d;
    logic       multi_d;
    logic       err_d;
    logic [7:0] rem;

    // Index of the next bit to serve in the chosen order.
    function automatic logic [2:0] pri(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign req_ready = (state == IDLE);
    assign rem       = pending & ~(8'd1 << code);

    always_comb begin
        state_d   = state;
        pending_d = pending;
        code_d    = code;
        valid_d   = code_valid;
        last_d    = code_last;
        multi_d   = multi;
        err_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_in != 8'h00) begin
                        pending_d = req_in;
                        code_d    = pri(req_in);
                        valid_d   = 1'b1;
                        last_d    = ($countones(req_in) == 1);
                        multi_d   = ($countones(req_in) > 1);
                        state_d   = SERVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (code_valid && code_ready) begin
                    pending_d = rem;
                    if (rem != 8'h00) begin
                        code_d = pri(rem);
                        last_d = ($countones(rem) == 1);
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        multi_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 8'h00;
            code       <= 3'd0;
            code_valid <= 1'b0;
            code_last  <= 1'b0;
            multi      <= 1'b0;
            err_zero   <= 1'b0;
        end else begin
            state      <= state_d;
            pending    <= pending_d;
            code       <= code_d;
            code_valid <= valid_d;
            code_last  <= last_d;
            multi      <= multi_d;
            err_zero   <= err_d;
        end
    end

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Directed bench for encoder8to3_seq; one LSB-first and one MSB-first
// instance share the same stimulus and are checked side by side.
module tb_encoder8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       req_valid;
    logic       code_ready;

    logic       rdy_l, cv_l, last_l, multi_l, ez_l;
    logic [2:0] code_l;
    logic       rdy_m, cv_m, last_m, multi_m, ez_m;
    logic [2:0] code_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder8to3_seq #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .req_in(req_in), .req_valid(req_valid),
        .req_ready(rdy_l), .code(code_l), .code_valid(cv_l),
        .code_ready(code_ready), .code_last(last_l), .multi(multi_l),
        .err_zero(ez_l)
    );

    encoder8to3_seq #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .req_in(req_in), .req_valid(req_valid),
        .req_ready(rdy_m), .code(code_m), .code_valid(cv_m),
        .code_ready(code_ready), .code_last(last_m), .multi(multi_m),
        .err_zero(ez_m)
    );

    typedef struct {
        logic [7:0]  vec;
        int          n;
        logic [31:0] lsb;
        logic [31:0] msb;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " req_ready_l"}, 8'(rdy_l), 8'd1);
        chk({tag, " req_ready_m"}, 8'(rdy_m), 8'd1);
        chk({tag, " code_valid_l"}, 8'(cv_l), 8'd0);
        chk({tag, " code_valid_m"}, 8'(cv_m), 8'd0);
        chk({tag, " multi_l"}, 8'(multi_l), 8'd0);
        chk({tag, " code_last_l"}, 8'(last_l), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        tv[0] = '{8'b0010_0000, 1, 32'h5, 32'h5};
        tv[1] = '{8'b1000_0101, 3, 32'h720, 32'h027};
        tv[2] = '{8'h81, 2, 32'h70, 32'h07};
        tv[3] = '{8'h5A, 4, 32'h6431, 32'h1346};
        tv[4] = '{8'h01, 1, 32'h0, 32'h0};
        tv[5] = '{8'h80, 1, 32'h7, 32'h7};

        rst        = 1'b1;
        req_in     = 8'h00;
        req_valid  = 1'b0;
        code_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset code_l", 8'(code_l), 8'd0);
        chk("reset err_zero_l", 8'(ez_l), 8'd0);

        // Table: back-to-back vectors with code_ready held high.
        code_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_in    = tv[i].vec;
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            req_in    = 8'hFF;
            for (int j = 0; j < tv[i].n; j++) begin
                chk($sformatf("v%0d[%0d] code_l", i, j), 8'(code_l),
                    8'(tv[i].lsb[4*j +: 3]));
                chk($sformatf("v%0d[%0d] code_m", i, j), 8'(code_m),
                    8'(tv[i].msb[4*j +: 3]));
                chk($sformatf("v%0d[%0d] valid", i, j), 8'({cv_l, cv_m}),
                    8'd3);
                chk($sformatf("v%0d[%0d] last", i, j), 8'({last_l, last_m}),
                    (j == tv[i].n - 1) ? 8'd3 : 8'd0);
                chk($sformatf("v%0d[%0d] multi", i, j),
                    8'({multi_l, multi_m}), (tv[i].n > 1) ? 8'd3 : 8'd0);
                chk($sformatf("v%0d[%0d] req_ready", i, j), 8'(rdy_l), 8'd0);
                step();
            end
            chk_idle($sformatf("v%0d done", i));
        end

        // 8'hFF with code_ready pattern 1,0,0 repeating.
        req_in    = 8'hFF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            logic r;
            chk($sformatf("ff c%0d code_l", c), 8'(code_l), 8'(idx));
            chk($sformatf("ff c%0d code_m", c), 8'(code_m), 8'(7 - idx));
            chk($sformatf("ff c%0d last", c), 8'({last_l, last_m}),
                (idx == 7) ? 8'd3 : 8'd0);
            chk($sformatf("ff c%0d valid", c), 8'({cv_l, cv_m}), 8'd3);
            r = (c % 3 == 0);
            code_ready = r;
            step();
            if (r) idx++;
        end
        chk("ff handshakes", 8'(idx), 8'd8);
        chk_idle("ff done");

        // Zero vector: one-cycle err_zero, nothing emitted.
        code_ready = 1'b1;
        req_in     = 8'h00;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        chk("zero err_l", 8'(ez_l), 8'd1);
        chk("zero err_m", 8'(ez_m), 8'd1);
        chk_idle("zero");
        step();
        chk("zero err drop", 8'({ez_l, ez_m}), 8'd0);
        chk_idle("zero after");

        // Reset in the middle of an 8'h0F batch.
        req_in    = 8'h0F;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rst0 code_l", 8'(code_l), 8'd0);
        chk("rst0 code_m", 8'(code_m), 8'd3);
        step();
        step();
        chk("rst2 code_l", 8'(code_l), 8'd2);
        chk("rst2 code_m", 8'(code_m), 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("midrst");
        chk("midrst code", 8'({code_l, code_m}), 8'd0);
        chk("midrst multi_m", 8'(multi_m), 8'd0);
        req_in    = 8'h10;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("fresh code_l", 8'(code_l), 8'd4);
        chk("fresh code_m", 8'(code_m), 8'd4);
        chk("fresh last", 8'({last_l, last_m}), 8'd3);
        chk("fresh multi", 8'({multi_l, multi_m}), 8'd0);
        step();
        chk_idle("fresh done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
